// File: rtl/heart_bit_monitor.sv
// heart_bit_monitor
//   Receiving end of a heart-bit link. Samples the incoming heart-bit square
//   wave, measures every half period (edge to edge, either polarity) in clk
//   cycles and checks it against Half_Period_Counts +/- Tolerance_Counts.
//   After Lock_Edges consecutive in-window measurements the monitor is
//   locked and drives alive. A locked heartbeat that drifts out of the window
//   or stops toggling sets the sticky fault flag.
//
//   Optional feature macro: HEART_MON_SYNC_EN
//     defined   : heart_bit_in passes through a 2-FF synchronizer before sync_q
//                 (use for inputs asynchronous to clk).
//     undefined : heart_bit_in is registered once into sync_q and must be
//                 synchronous to clk.
//
//   Ports
//     clk              in   system clock
//     rst              in   asynchronous active-high reset
//     enable           in   monitor enable, low forces IDLE
//     heart_bit_in     in   monitored heart-bit
//     fault_clr        in   synchronous clear of the sticky fault
//     alive            out  high while locked
//     fault            out  sticky loss-of-lock flag
//     meas_valid       out  one-cycle pulse per captured measurement
//     half_period_meas out  last captured edge-to-edge cycle count
module heart_bit_monitor #(
    parameter int Half_Period_Counts = 50_000_000,
    parameter int Tolerance_Counts   = 500_000,
    parameter int Lock_Edges         = 2,
    localparam int Max_Count         = Half_Period_Counts + Tolerance_Counts,
    localparam int Cnt_W             = $clog2(Max_Count + 2)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             heart_bit_in,
    input  logic             fault_clr,
    output logic             alive,
    output logic             fault,
    output logic             meas_valid,
    output logic [Cnt_W-1:0] half_period_meas
);

    // good_cnt is cleared on lock, so it only ever holds 0..Lock_Edges-1.
    localparam int GOOD_W = (Lock_Edges < 2) ? 1 : $clog2(Lock_Edges);

    localparam logic [Cnt_W-1:0]  CNT_MIN   = Cnt_W'(Half_Period_Counts - Tolerance_Counts);
    localparam logic [Cnt_W-1:0]  CNT_MAX   = Cnt_W'(Max_Count);
    localparam logic [Cnt_W-1:0]  CNT_SAT   = Cnt_W'(Max_Count + 1);
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(Lock_Edges - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_EDGE,
        S_MEASURE,
        S_LOCKED,
        S_LOST
    } state_t;

    state_t            state_q, state_d;
    logic [Cnt_W-1:0]  cnt_q, cnt_d;
    logic [Cnt_W-1:0]  meas_q, meas_d;
    logic [GOOD_W-1:0] good_q, good_d;
    logic              alive_q, alive_d;
    logic              fault_q, fault_d;
    logic              mvld_q, mvld_d;
    logic              sync_q, sync_d;
    logic              sync_prev_q, sync_prev_d;

    logic              hb_edge;
    logic              in_window;
    logic              timeout;
    logic              fault_set;

`ifdef HEART_MON_SYNC_EN
    logic [1:0] meta_q, meta_d;

    always_comb begin
        meta_d = {meta_q[0], heart_bit_in};
        sync_d = meta_q[1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '0;
        end else begin
            meta_q <= meta_d;
        end
    end
`else
    always_comb sync_d = heart_bit_in;
`endif

    always_comb sync_prev_d = sync_q;

    // Either polarity of the heart-bit counts as an edge.
    assign hb_edge   = sync_q ^ sync_prev_q;
    assign in_window = (cnt_q >= CNT_MIN) && (cnt_q <= CNT_MAX);
    // cnt only reaches the saturation value when no edge arrived in time.
    assign timeout   = !hb_edge && (cnt_q == CNT_SAT);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        good_d    = good_q;
        meas_d    = meas_q;
        mvld_d    = 1'b0;
        fault_set = 1'b0;

        // The edge cycle loads 1, so the value seen on the next edge is the
        // number of cycles between the two edges.
        if (hb_edge) begin
            cnt_d = Cnt_W'(1);
        end else if (cnt_q != CNT_SAT) begin
            cnt_d = cnt_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                cnt_d  = '0;
                good_d = '0;
                state_d = S_WAIT_EDGE;
            end
            S_WAIT_EDGE: begin
                // The first edge only aligns the counter; nothing is measured.
                good_d = '0;
                if (hb_edge) begin
                    state_d = S_MEASURE;
                end
            end
            S_MEASURE: begin
                if (hb_edge) begin
                    meas_d = cnt_q;
                    mvld_d = 1'b1;
                    if (in_window) begin
                        if (good_q == GOOD_LAST) begin
                            good_d  = '0;
                            state_d = S_LOCKED;
                        end else begin
                            good_d = good_q + 1'b1;
                        end
                    end else begin
                        good_d = '0;
                    end
                end else if (timeout) begin
                    good_d  = '0;
                    state_d = S_WAIT_EDGE;
                end
            end
            S_LOCKED: begin
                if (hb_edge) begin
                    meas_d = cnt_q;
                    mvld_d = 1'b1;
                    if (!in_window) begin
                        fault_set = 1'b1;
                        state_d   = S_LOST;
                    end
                end else if (timeout) begin
                    fault_set = 1'b1;
                    state_d   = S_LOST;
                end
            end
            S_LOST: begin
                // This edge restarts timing; it is not measured.
                good_d = '0;
                if (hb_edge) begin
                    state_d = S_MEASURE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Disable overrides everything; fault and the last measurement stay.
        if (!enable) begin
            state_d   = S_IDLE;
            cnt_d     = '0;
            good_d    = '0;
            meas_d    = meas_q;
            mvld_d    = 1'b0;
            fault_set = 1'b0;
        end

        // Set wins over a simultaneous clear.
        if (fault_set) begin
            fault_d = 1'b1;
        end else if (fault_clr) begin
            fault_d = 1'b0;
        end else begin
            fault_d = fault_q;
        end

        alive_d = (state_d == S_LOCKED);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            good_q      <= '0;
            meas_q      <= '0;
            mvld_q      <= 1'b0;
            alive_q     <= 1'b0;
            fault_q     <= 1'b0;
            sync_q      <= 1'b0;
            sync_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            good_q      <= good_d;
            meas_q      <= meas_d;
            mvld_q      <= mvld_d;
            alive_q     <= alive_d;
            fault_q     <= fault_d;
            sync_q      <= sync_d;
            sync_prev_q <= sync_prev_d;
        end
    end

    assign alive            = alive_q;
    assign fault            = fault_q;
    assign meas_valid       = mvld_q;
    assign half_period_meas = meas_q;

endmodule

// File: tb/tb_heart_bit_monitor.sv
// Testbench for heart_bit_monitor. Stimulus is a sequence of heart-bit
// half periods; a reference model working on whole half periods predicts
// each measurement (queued for the meas_valid monitor) and the alive/fault
// status after each edge.
module tb_heart_bit_monitor;

    localparam int HALF = 10;
    localparam int TOL  = 2;
    localparam int LOCK = 2;
    localparam int MAXC = HALF + TOL;
    localparam int CW   = $clog2(MAXC + 2);

`ifdef HEART_MON_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    localparam int M_IDLE = 0;
    localparam int M_WAIT = 1;
    localparam int M_MEAS = 2;
    localparam int M_LOCK = 3;
    localparam int M_LOST = 4;

    logic          clk;
    logic          rst;
    logic          enable;
    logic          hb;
    logic          fault_clr;
    logic          alive;
    logic          fault;
    logic          meas_valid;
    logic [CW-1:0] hpm;

    heart_bit_monitor #(
        .Half_Period_Counts (HALF),
        .Tolerance_Counts   (TOL),
        .Lock_Edges         (LOCK)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .enable           (enable),
        .heart_bit_in     (hb),
        .fault_clr        (fault_clr),
        .alive            (alive),
        .fault            (fault),
        .meas_valid       (meas_valid),
        .half_period_meas (hpm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;
    int exp_q[$];

    // reference model state
    int m_state = M_IDLE;
    int m_good  = 0;
    int m_fault = 0;
    int m_last  = 0;
    int last_tgl = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit in_win(input int g);
        return (g >= HALF - TOL) && (g <= MAXC);
    endfunction

    // Effect of one heart-bit edge arriving g cycles after the previous one.
    task automatic model_edge(input int g, input bit clr);
        bit set_now;
        set_now = 1'b0;
        case (m_state)
            M_WAIT, M_LOST: begin
                m_state = M_MEAS;
                m_good  = 0;
            end
            M_MEAS: begin
                if (g > MAXC + 1) begin
                    m_good = 0;          // timed out earlier, this edge re-aligns
                end else begin
                    exp_q.push_back(g);
                    m_last = g;
                    if (in_win(g)) begin
                        m_good++;
                        if (m_good >= LOCK) begin
                            m_state = M_LOCK;
                            m_good  = 0;
                        end
                    end else begin
                        m_good = 0;
                    end
                end
            end
            M_LOCK: begin
                if (g > MAXC + 1) begin
                    m_fault = 1;         // lost on timeout, before this edge
                    m_state = M_MEAS;
                    m_good  = 0;
                end else begin
                    exp_q.push_back(g);
                    m_last = g;
                    if (!in_win(g)) begin
                        set_now = 1'b1;
                        m_state = M_LOST;
                    end
                end
            end
            default: ;
        endcase
        if (set_now) m_fault = 1;
        else if (clr) m_fault = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Toggle the heart-bit g cycles after the previous toggle, optionally
    // pulsing fault_clr in the cycle the edge is detected, then check status.
    task automatic next_edge(input int g, input bit clr);
        int gap;
        while (cyc - last_tgl < g) idle(1);
        gap      = cyc - last_tgl;
        last_tgl = cyc;
        hb       = ~hb;
        model_edge(gap, clr);
        idle(LAT);
        fault_clr = clr;
        idle(1);
        fault_clr = 1'b0;
        idle(3 - LAT);
        chk("alive_after_edge", int'(alive), (m_state == M_LOCK) ? 1 : 0);
        chk("fault_after_edge", int'(fault), m_fault);
        chk("hpm_after_edge", int'(hpm), m_last);
    endtask

    task automatic model_reset();
        m_state = M_WAIT;
        m_good  = 0;
        m_fault = 0;
        m_last  = 0;
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (!rst && meas_valid) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL meas_unexpected: got pulse with %0d, expected none (t=%0t)", hpm, $time);
            end else begin
                chk("meas_value", int'(hpm), exp_q.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        bit c;
        rst = 1'b1; enable = 1'b0; hb = 1'b0; fault_clr = 1'b0;
        idle(3);
        chk("rst_alive", int'(alive), 0);
        chk("rst_fault", int'(fault), 0);
        chk("rst_meas_valid", int'(meas_valid), 0);
        chk("rst_hpm", int'(hpm), 0);
        rst = 1'b0;
        idle(2);
        chk("idle_alive", int'(alive), 0);

        // nominal lock
        enable = 1'b1; model_reset(); last_tgl = cyc;
        idle(3);
        next_edge(5, 0);
        next_edge(10, 0);
        next_edge(10, 0);
        next_edge(10, 0);

        // one long half period, then relock with fault retained
        next_edge(13, 0);
        next_edge(10, 0);
        next_edge(10, 0);
        next_edge(10, 0);

        // loss coinciding with fault_clr: set wins; then isolated clear
        next_edge(7, 1);
        idle(2);
        fault_clr = 1'b1; idle(1); fault_clr = 1'b0;
        m_fault = 0;
        chk("fault_after_clr", int'(fault), 0);
        next_edge(10, 0);
        next_edge(10, 0);
        next_edge(10, 0);

        // input held constant while locked: timeout exactly Max_Count+1 after the edge
        while (cyc - last_tgl < LAT + 13) idle(1);
        chk("hold_alive_before", int'(alive), 1);
        chk("hold_fault_before", int'(fault), 0);
        idle(1);
        m_state = M_LOST; m_fault = 1;
        chk("hold_alive_after", int'(alive), 0);
        chk("hold_fault_after", int'(fault), 1);

        // 8, 12 lock, 7 loses, then relock
        next_edge(20, 0);
        next_edge(8, 0);
        next_edge(12, 0);
        next_edge(7, 0);
        next_edge(10, 0);
        next_edge(10, 0);
        next_edge(10, 0);

        // asynchronous reset mid-lock
        idle(3);
        #2;
        rst = 1'b1; hb = 1'b0;
        #1;
        chk("arst_alive", int'(alive), 0);
        chk("arst_fault", int'(fault), 0);
        chk("arst_meas_valid", int'(meas_valid), 0);
        chk("arst_hpm", int'(hpm), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset(); last_tgl = cyc;
        next_edge(5, 0);
        next_edge(10, 0);
        next_edge(10, 0);

        // enable dropped while locked
        idle(2);
        enable = 1'b0;
        idle(1);
        chk("dis_alive", int'(alive), 0);
        chk("dis_fault", int'(fault), m_fault);
        chk("dis_hpm", int'(hpm), m_last);
        idle(2);
        enable = 1'b1; model_reset(); m_last = int'(hpm);
        m_last = 10;
        m_fault = 0;
        idle(3);
        next_edge(5, 0);
        next_edge(11, 0);
        next_edge(9, 0);

        // randomized half periods
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 3) != 0) g = int'($urandom_range(8, 12));
            else g = int'($urandom_range(5, 16));
            c = ($urandom_range(0, 9) == 0);
            next_edge(g, c);
        end

        idle(5);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/heart_bit_monitor.md
# heart_bit_monitor

Receiving end of the heart-bit signal. It samples an incoming heart-bit square wave, measures each half period in `clk` cycles and checks it against a nominal count with a tolerance window. It asserts `alive` once the signal is locked, and raises a sticky `fault` when a locked heartbeat stops or drifts. It sits on the monitoring side of a board or FPGA link, watching the alive-system toggle produced by a heart-bit generator.

## Interface
- `Half_Period_Counts`, 50_000_000, nominal `clk` cycles between heart-bit edges.
- `Tolerance_Counts`, 500_000, allowed ± deviation from nominal (must be < `Half_Period_Counts`).
- `Lock_Edges`, 2, consecutive in-window measurements required to lock (≥1).
- Derived: `Max_Count = Half_Period_Counts + Tolerance_Counts`, `Cnt_W = $clog2(Max_Count + 2)`.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `enable`  in  1  monitor enable; low forces IDLE.
- `heart_bit_in`  in  1  monitored heart-bit; asynchronous to `clk` unless configured otherwise.
- `fault_clr`  in  1  synchronous clear of sticky `fault`.
- `alive`  out  1  high while in LOCKED.
- `fault`  out  1  sticky; set on loss of lock.
- `meas_valid`  out  1  one-cycle pulse when a new measurement is captured.
- `half_period_meas`  out  `Cnt_W`  last captured edge-to-edge cycle count; holds between captures.

## Operation
- Edge detect: `edge = sync_q ^ sync_prev`. Both polarities count as heart-bit edges.
- Period counter `cnt`:
  - edge cycle: loads 1;
  - otherwise: increments, saturating at `Max_Count+1`.
  - With this rule, the value present when the next edge is detected equals the number of cycles between the two edges.
- In window: `Half_Period_Counts - Tolerance_Counts ≤ cnt ≤ Max_Count`.
- Timeout: `cnt == Max_Count+1` with no edge.
- States:
  - IDLE: counters held at 0, `alive=0`. With `enable=1` → WAIT_EDGE.
  - WAIT_EDGE: first edge → MEASURE. No measurement is taken, since the start of the period is unaligned.
  - MEASURE: each edge captures `cnt` into `half_period_meas` and pulses `meas_valid`.
    - In window: `good_cnt++`. When it reaches `Lock_Edges` → LOCKED.
    - Out of window: `good_cnt=0`, stay in MEASURE.
    - Timeout → WAIT_EDGE, `good_cnt=0`.
  - LOCKED: each edge captures and pulses `meas_valid`.
    - Out of window or timeout → LOST, and `fault` is set.
  - LOST: `alive=0`. Next edge → MEASURE with `good_cnt=0`; that edge restarts timing and is not measured.
- `enable` low in any state → IDLE on the next clock. `fault` and `half_period_meas` are retained.
- `fault`:
  - Set only on the LOCKED→LOST transition.
  - Cleared by `fault_clr` or `rst`.
  - If set and clear occur in the same cycle, set wins.
- `rst` mid-operation: all state is cleared immediately, without waiting for a clock edge.

## Timing
- Reset values: `alive=0`, `fault=0`, `meas_valid=0`, `half_period_meas=0`, state IDLE, `cnt=0`, `good_cnt=0`.
- Input latency with `HEART_MON_SYNC_EN`: a change in `heart_bit_in` sampled at clock edge k is detected (`edge=1`) in the cycle after edge k+2.
- Input latency without `HEART_MON_SYNC_EN`: the change is detected in the cycle after edge k.
- `meas_valid`, `half_period_meas`, state and `fault` update on the clock edge that ends the `edge` cycle.
- `alive` is registered from the state: it rises in the first cycle the state is LOCKED and falls in the first cycle the state is LOST or IDLE.
- Timeout is flagged exactly `Max_Count+1` cycles after the last edge cycle.
- One measurement per edge. Edges closer than 1 cycle apart cannot occur after edge detection.

## Configuration
- `HEART_MON_SYNC_EN` defined: `heart_bit_in` passes through a 2-FF synchronizer into `sync_q`. For async inputs.
- Not defined: `heart_bit_in` is registered once into `sync_q`, and the input must be synchronous to `clk`. All other behaviour is identical; only the detection latency changes.

## Test plan
All scenarios use `Half_Period_Counts=10`, `Tolerance_Counts=2`, `Lock_Edges=2`, sync enabled.
- Toggle every 10 cycles after `enable=1` → first edge has no `meas_valid`; edges 2 and 3 each pulse `meas_valid` with `half_period_meas=10`; `alive=1` the cycle after edge 3.
- Locked, then one half period of 13 cycles → `half_period_meas=13`, `fault=1`, `alive=0`. The next edge returns to MEASURE, and the monitor relocks after 2 good periods (`fault` stays 1).
- Locked, then input held constant → `alive` falls and `fault` rises exactly 13 cycles after the last detected edge.
- Periods 8, 12, 7, 10 from MEASURE → `meas_valid` each time. `good_cnt` goes 1, 2 → lock at 12. Then 7 → LOST with fault.
- `fault=1`, and `fault_clr` is pulsed in the same cycle as a new lock loss → `fault` stays 1. A later isolated `fault_clr` → `fault=0`.
- `rst` pulsed mid-lock between clock edges → `alive`, `fault`, `meas_valid` and `half_period_meas` go to 0 immediately. After release, the lock sequence restarts from WAIT_EDGE.
- `enable` dropped while locked → `alive=0` next cycle, `fault` and `half_period_meas` unchanged.
